// File: rtl/deinterleave_pkg.sv
// Shared definitions for the OFDM deinterleaver: modulation codes, subcarrier
// and column constants, and the rate-to-modulation decode used by the reader.
package deinterleave_pkg;

    localparam int N_SD_LEGACY  = 48;
    localparam int N_SD_HT      = 52;
    localparam int N_COL_LEGACY = 16;
    localparam int N_COL_HT     = 13;

    typedef enum logic [2:0] {
        MOD_BPSK   = 3'd1,
        MOD_QPSK   = 3'd2,
        MOD_QAM_16 = 3'd3,
        MOD_QAM_64 = 3'd4
    } mod_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_t;

    // Per-symbol constants the address generator needs. q_step is N_SD/N_COL,
    // the subcarrier advance when stepping one interleaver column.
    typedef struct packed {
        logic [2:0] n_bpsc;
        logic [1:0] s;
        logic [8:0] n_cbps;
        logic [3:0] col_max;
        logic [2:0] q_step;
    } mod_params_t;

    // code = {rate[7], rate[3:0]}
    function automatic mod_t decode_mod(input logic [4:0] code);
        mod_t m;
        m = MOD_BPSK;
        if (code[4]) begin
            case (code[3:0])
                4'd1, 4'd2:       m = MOD_QPSK;
                4'd3, 4'd4:       m = MOD_QAM_16;
                4'd5, 4'd6, 4'd7: m = MOD_QAM_64;
                default:          m = MOD_BPSK;
            endcase
        end else begin
            case (code[3:0])
                4'b1010, 4'b1110: m = MOD_QPSK;
                4'b1001, 4'b1101: m = MOD_QAM_16;
                4'b1000, 4'b1100: m = MOD_QAM_64;
                default:          m = MOD_BPSK;
            endcase
        end
        return m;
    endfunction

    function automatic mod_params_t mod_params(input logic [4:0] code);
        mod_params_t p;
        logic        ht;
        ht        = code[4];
        p.col_max = ht ? 4'(N_COL_HT - 1) : 4'(N_COL_LEGACY - 1);
        p.q_step  = ht ? 3'(N_SD_HT / N_COL_HT) : 3'(N_SD_LEGACY / N_COL_LEGACY);
        case (decode_mod(code))
            MOD_QPSK:   begin p.n_bpsc = 3'd2; p.s = 2'd1; end
            MOD_QAM_16: begin p.n_bpsc = 3'd4; p.s = 2'd2; end
            MOD_QAM_64: begin p.n_bpsc = 3'd6; p.s = 2'd3; end
            default:    begin p.n_bpsc = 3'd1; p.s = 2'd1; end
        endcase
        p.n_cbps = 9'((ht ? N_SD_HT : N_SD_LEGACY) * int'(p.n_bpsc));
        return p;
    endfunction

endpackage

// File: rtl/deinterleave_if.sv
// Data-path bundle between demodulator, deinterleaver and depuncturer.
// Strobe semantics: a word/bit transfers on every enabled clock where its strobe
// is high; there is no back-pressure, so the consumer must accept every strobe.
interface deinterleave_if;
    logic [5:0] in_bits;
    logic       input_strobe;
    logic       out_bit;
    logic       output_strobe;
    logic       out_last;

    modport master (
        output in_bits,
        output input_strobe,
        input  out_bit,
        input  output_strobe,
        input  out_last
    );

    modport slave (
        input  in_bits,
        input  input_strobe,
        output out_bit,
        output output_strobe,
        output out_last
    );
endinterface

// File: rtl/deinterleave_addr_gen.sv
// Read-address generator: walks k = 0..N_CBPS-1 and emits the (subcarrier, bit)
// of deinterleaved bit j using counters only.
module deint_addr_gen
    import deinterleave_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] code,
    input  logic       start,
    input  logic       run,
    output logic       valid,
    output logic [5:0] sub,
    output logic [2:0] bit_idx,
    output logic       last
);

    mod_params_t prm;

    // i = N_ROW*c + r is held as (i_q, row_r) = (i / N_BPSC, i mod N_BPSC);
    // s always divides N_BPSC, so the j-permutation never leaves subcarrier i_q.
    logic [8:0] k,       k_n;
    logic [3:0] col,     col_n;
    logic [1:0] c_mod,   c_mod_n;
    logic [2:0] row_q,   row_q_n;
    logic [2:0] row_r,   row_r_n;
    logic [1:0] row_mod, row_mod_n;
    logic [5:0] i_q,     i_q_n;
    logic [1:0] diff;

    assign prm   = mod_params(code);
    assign valid = start | run;
    assign last  = valid && (k == prm.n_cbps - 9'd1);
    assign sub   = i_q;

    always_comb begin
        diff = 2'd0;
        if (row_mod >= c_mod) diff = row_mod - c_mod;
        else                  diff = row_mod + prm.s - c_mod;
        bit_idx = row_r - {1'b0, row_mod} + {1'b0, diff};
    end

    always_comb begin
        k_n       = k;
        col_n     = col;
        c_mod_n   = c_mod;
        row_q_n   = row_q;
        row_r_n   = row_r;
        row_mod_n = row_mod;
        i_q_n     = i_q;
        if (valid) begin
            if (last) begin
                k_n       = '0;
                col_n     = '0;
                c_mod_n   = '0;
                row_q_n   = '0;
                row_r_n   = '0;
                row_mod_n = '0;
                i_q_n     = '0;
            end else begin
                k_n = k + 9'd1;
                if (col == prm.col_max) begin
                    col_n   = '0;
                    c_mod_n = '0;
                    if (row_r == prm.n_bpsc - 3'd1) begin
                        row_r_n   = '0;
                        row_mod_n = '0;
                        row_q_n   = row_q + 3'd1;
                    end else begin
                        row_r_n   = row_r + 3'd1;
                        row_mod_n = (row_mod == prm.s - 2'd1) ? 2'd0 : row_mod + 2'd1;
                    end
                    i_q_n = {3'b000, row_q_n};
                end else begin
                    col_n   = col + 4'd1;
                    c_mod_n = (c_mod == prm.s - 2'd1) ? 2'd0 : c_mod + 2'd1;
                    i_q_n   = i_q + {3'b000, prm.q_step};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k       <= '0;
            col     <= '0;
            c_mod   <= '0;
            row_q   <= '0;
            row_r   <= '0;
            row_mod <= '0;
            i_q     <= '0;
        end else if (enable) begin
            k       <= k_n;
            col     <= col_n;
            c_mod   <= c_mod_n;
            row_q   <= row_q_n;
            row_r   <= row_r_n;
            row_mod <= row_mod_n;
            i_q     <= i_q_n;
        end
    end

endmodule

// File: rtl/deinterleave.sv
// OFDM symbol deinterleaver: ping-pong buffer of 6-bit subcarrier words,
// streamed out one coded bit per clock in encoder order.
module deinterleave
    import deinterleave_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [7:0]     rate,
    deinterleave_if.slave  bus,
    output logic           overflow,
    output rd_state_t      dbg_state
);

    logic [5:0] mem [0:127];

    logic       wb, rb;
    logic [5:0] wcount;
    logic [1:0] full;
    logic [4:0] bank_code [0:1];
    logic       overflow_q;

    logic [4:0] rate_code;
    logic       unused_rate_bits;
    logic       at_first, wr_block, wr_en, wr_done, sym_ht, free_rb;
    logic [5:0] sym_len;

    rd_state_t  state, state_n;
    logic       start, run;
    logic       issue, gen_last;
    logic [5:0] gen_sub;
    logic [2:0] gen_bit;

    logic [5:0] rd_word;
    logic       s1_valid, s1_last;
    logic [2:0] s1_bit;
    logic       out_bit_q, strobe_q, last_q;

    assign rate_code        = {rate[7], rate[3:0]};
    assign unused_rate_bits = ^rate[6:4];

    // Writer: the symbol length comes from the live rate on word 0 and from the
    // latched code afterwards, so mid-symbol rate changes are ignored.
    assign at_first = (wcount == 6'd0);
    assign wr_block = at_first & full[wb];
    assign wr_en    = enable & bus.input_strobe & ~wr_block;
    assign sym_ht   = at_first ? rate_code[4] : bank_code[wb][4];
    assign sym_len  = sym_ht ? 6'(N_SD_HT) : 6'(N_SD_LEGACY);
    assign wr_done  = wr_en & (wcount == sym_len - 6'd1);
    assign free_rb  = enable & issue & gen_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb           <= 1'b0;
            rb           <= 1'b0;
            wcount       <= '0;
            full         <= '0;
            bank_code[0] <= '0;
            bank_code[1] <= '0;
            overflow_q   <= 1'b0;
        end else if (enable) begin
            if (bus.input_strobe & wr_block) overflow_q <= 1'b1;
            if (wr_en) begin
                if (at_first) bank_code[wb] <= rate_code;
                if (wr_done) begin
                    wcount <= '0;
                    wb     <= ~wb;
                end else begin
                    wcount <= wcount + 6'd1;
                end
            end
            if (wr_done) full[wb] <= 1'b1;
            if (free_rb) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end

    // Reader FSM: state register / next state / outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      state <= RD_IDLE;
        else if (enable) state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RD_IDLE:   if (full[rb]) state_n = RD_ACTIVE;
            RD_ACTIVE: if (gen_last) state_n = RD_IDLE;
            default:   state_n = RD_IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        run   = 1'b0;
        case (state)
            RD_IDLE:   start = full[rb];
            RD_ACTIVE: run   = 1'b1;
            default:   start = 1'b0;
        endcase
    end

    deint_addr_gen u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .code    (bank_code[rb]),
        .start   (start),
        .run     (run),
        .valid   (issue),
        .sub     (gen_sub),
        .bit_idx (gen_bit),
        .last    (gen_last)
    );

    // Writer and reader always address different banks, so no collision case.
    always_ff @(posedge clock) begin
        if (wr_en) mem[{wb, wcount}] <= bus.in_bits;
        if (enable) rd_word <= mem[{rb, gen_sub}];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_bit    <= '0;
            out_bit_q <= 1'b0;
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
        end else if (enable) begin
            s1_valid <= issue;
            s1_last  <= gen_last;
            s1_bit   <= gen_bit;
            strobe_q <= s1_valid;
            last_q   <= s1_valid & s1_last;
            if (s1_valid) out_bit_q <= rd_word[s1_bit];
        end
    end

    assign bus.out_bit       = out_bit_q;
    assign bus.output_strobe = strobe_q;
    assign bus.out_last      = last_q;
    assign overflow          = overflow_q;
    assign dbg_state         = state;

endmodule
